fifo_spram_ctrl: RTL and testbench

Sequencing controller that wraps one single-port FIFO RAM bank (`fifo_bank`) into a valid/ready streaming FIFO. It owns the read/write pointers, occupancy and the bank's one-cycle deferred-write slot, and issues at most one legal bank command pair per cycle. It also hides the bank's 2-cycle read latency behind a small prefetch buffer. It sits between a producer stream and a consumer stream, with `fifo_bank` instantiated beside it.

---
 rtl/fifo_spram_pkg.sv | 13 +
 rtl/fifo_prefetch_buf.sv | 50 +++++
 rtl/fifo_spram_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_spram_ctrl.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_spram_pkg.sv
// fifo_spram_pkg: shared constants for the single-port FIFO controller.
// Bank read latency and the prefetch sizing rule derived from it.
package fifo_spram_pkg;

   localparam int BANK_RD_LAT  = 2;
   localparam int PREFETCH_MIN = 3;

   // Prefetch must absorb every read in flight plus the word being shown.
   function automatic bit prefetch_ok(input int pf);
      return (pf >= BANK_RD_LAT + 1) && (pf >= PREFETCH_MIN);
   endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// fifo_prefetch_buf: small register FIFO holding words already read
// from the bank, so the head is visible with zero latency.
module fifo_prefetch_buf
   import fifo_spram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = PREFETCH_MIN,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [CNT_WIDTH-1:0]  count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   assign head = mem[rd_ptr];

   // Storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fifo_spram_ctrl.sv
// fifo_spram_ctrl: valid/ready FIFO around one single-port bank, owning
// pointers, the deferred-write busy slot and prefetch read credits.
module fifo_spram_ctrl
   import fifo_spram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
   parameter int PREFETCH   = PREFETCH_MIN,
   parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH + PREFETCH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [LVL_WIDTH-1:0]  level,
   output logic                  bank_wen,
   output logic [ADDR_WIDTH-1:0] bank_waddr,
   output logic [DATA_WIDTH-1:0] bank_wdata,
   output logic                  bank_ren,
   output logic [ADDR_WIDTH-1:0] bank_raddr,
   input  logic [DATA_WIDTH-1:0] bank_rdata
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PF_W  = $clog2(PREFETCH + 1);

   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [CNT_W-1:0]      ram_cnt;
   logic                  busy;
   logic [1:0]            rd_pipe;
   logic [PF_W-1:0]       pf_cnt;
   logic [PF_W:0]         credit;
   logic                  pop;

   if (!prefetch_ok(PREFETCH)) begin : g_bad_prefetch
      $error("fifo_spram_ctrl: PREFETCH must exceed the bank read latency");
   end

   // Bank command issue; nothing is issued in the slot after a wen+ren pair.
   always_comb begin
      credit     = {1'b0, pf_cnt}
                 + (PF_W + 1)'(rd_pipe[0])
                 + (PF_W + 1)'(rd_pipe[1]);
      in_ready   = rst_n && !busy && (ram_cnt < CNT_W'(FIFO_DEPTH));
      bank_wen   = in_valid && in_ready;
      bank_waddr = wptr;
      bank_wdata = bank_wen ? in_data : '0;
      bank_ren   = rst_n && !busy && (ram_cnt != '0)
                && (credit < (PF_W + 1)'(PREFETCH));
      bank_raddr = rptr;
      out_valid  = (pf_cnt != '0);
      pop        = out_valid && out_ready;
   end

   // Pointers, bank occupancy, busy slot and read-return shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         ram_cnt <= '0;
         busy    <= 1'b0;
         rd_pipe <= '0;
      end else begin
         busy    <= bank_wen && bank_ren;
         rd_pipe <= {rd_pipe[0], bank_ren};
         if (bank_wen) begin
            wptr <= (wptr == ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
         end
         if (bank_ren) begin
            rptr <= (rptr == ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
         end
         case ({bank_wen, bank_ren})
            2'b10:   ram_cnt <= ram_cnt + 1'b1;
            2'b01:   ram_cnt <= ram_cnt - 1'b1;
            default: ram_cnt <= ram_cnt;
         endcase
      end
   end

   // Words accepted and not yet popped, across bank and prefetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
      end else begin
         case ({bank_wen, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   fifo_prefetch_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (PREFETCH),
      .CNT_WIDTH  (PF_W)
   ) u_pf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_pipe[1]),
      .push_data (bank_rdata),
      .pop       (pop),
      .head      (out_data),
      .count     (pf_cnt)
   );

endmodule

// File: tb/tb_fifo_spram_ctrl.sv
// tb_fifo_spram_ctrl: directed bench for fifo_spram_ctrl with a behavioural
// single-port bank model; instance 0 has depth 16, instance 1 depth 12.
module tb_fifo_spram_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int LW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         in_valid;
   logic [1:0][DW-1:0] in_data;
   logic [1:0]         in_ready;
   logic [1:0]         out_valid;
   logic [1:0][DW-1:0] out_data;
   logic [1:0]         out_ready;
   logic [1:0][LW-1:0] level;
   logic [1:0]         b_wen;
   logic [1:0][AW-1:0] b_waddr;
   logic [1:0][DW-1:0] b_wdata;
   logic [1:0]         b_ren;
   logic [1:0][AW-1:0] b_raddr;
   logic [1:0][DW-1:0] b_rdata;

   logic [1:0]         mbusy = '0;
   logic [1:0]         pend_v = '0;
   logic [1:0][AW-1:0] pend_a;
   logic [1:0][DW-1:0] pend_d;
   logic [1:0][DW-1:0] r1;
   logic [DW-1:0]      mem [2][16];

   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] sb [$];
   int            exp_w [2];
   int            exp_r [2];
   logic [1:0]    acc_d;
   logic [1:0]    pop_d;

   fifo_spram_ctrl #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(16), .ADDR_WIDTH(AW),
      .PREFETCH(3), .LVL_WIDTH(LW)
   ) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
      .out_valid(out_valid[0]), .out_data(out_data[0]),
      .out_ready(out_ready[0]), .level(level[0]),
      .bank_wen(b_wen[0]), .bank_waddr(b_waddr[0]), .bank_wdata(b_wdata[0]),
      .bank_ren(b_ren[0]), .bank_raddr(b_raddr[0]), .bank_rdata(b_rdata[0])
   );

   fifo_spram_ctrl #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(12), .ADDR_WIDTH(AW),
      .PREFETCH(3), .LVL_WIDTH(LW)
   ) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
      .out_valid(out_valid[1]), .out_data(out_data[1]),
      .out_ready(out_ready[1]), .level(level[1]),
      .bank_wen(b_wen[1]), .bank_waddr(b_waddr[1]), .bank_wdata(b_wdata[1]),
      .bank_ren(b_ren[1]), .bank_raddr(b_raddr[1]), .bank_rdata(b_rdata[1])
   );

   // Bank model: 2-cycle read, write deferred one cycle when paired with a
   // read, and every command dropped in the busy cycle that follows.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (pend_v[k]) mem[k][pend_a[k]] <= pend_d[k];
         pend_v[k] <= 1'b0;
         if (!mbusy[k]) begin
            if (b_ren[k]) r1[k] <= mem[k][b_raddr[k]];
            if (b_wen[k] && b_ren[k]) begin
               pend_v[k] <= 1'b1;
               pend_a[k] <= b_waddr[k];
               pend_d[k] <= b_wdata[k];
            end else if (b_wen[k]) begin
               mem[k][b_waddr[k]] <= b_wdata[k];
            end
         end
         b_rdata[k] <= r1[k];
         mbusy[k] <= !mbusy[k] && b_wen[k] && b_ren[k];
      end
   end

   function automatic int depth_of(input int k);
      return (k == 0) ? 16 : 12;
   endfunction

   // One clock: sample at negedge (bank rules, pointer order, scoreboard),
   // then return 1 time unit after the next rising edge.
   task automatic cycle();
      logic [DW-1:0] want;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         acc_d[k] = 1'b0;
         pop_d[k] = 1'b0;
         if (mbusy[k]) begin
            n_chk++;
            if (b_wen[k] || b_ren[k]) begin
               n_fail++;
               $display("FAIL busy_cmd[%0d]: wen=%0b ren=%0b, want 0 0",
                        k, b_wen[k], b_ren[k]);
            end
         end
         if (b_wen[k]) begin
            n_chk++;
            if (b_waddr[k] !== AW'(exp_w[k])) begin
               n_fail++;
               $display("FAIL waddr[%0d]: got %0d, want %0d",
                        k, b_waddr[k], exp_w[k]);
            end
            exp_w[k] = (exp_w[k] == depth_of(k) - 1) ? 0 : exp_w[k] + 1;
         end
         if (b_ren[k]) begin
            n_chk++;
            if (b_raddr[k] !== AW'(exp_r[k])) begin
               n_fail++;
               $display("FAIL raddr[%0d]: got %0d, want %0d",
                        k, b_raddr[k], exp_r[k]);
            end
            exp_r[k] = (exp_r[k] == depth_of(k) - 1) ? 0 : exp_r[k] + 1;
         end
         if (in_valid[k] && in_ready[k]) begin
            acc_d[k] = 1'b1;
            sb.push_back(in_data[k]);
         end
         if (out_valid[k] && out_ready[k]) begin
            pop_d[k] = 1'b1;
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL pop_data[%0d]: got %h, want nothing (empty)",
                        k, out_data[k]);
            end else begin
               want = sb.pop_front();
               if (out_data[k] !== want) begin
                  n_fail++;
                  $display("FAIL pop_data[%0d]: got %h, want %h",
                           k, out_data[k], want);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int n);
      rst_n = 1'b0;
      in_valid = '0;
      out_ready = '0;
      in_data = '0;
      repeat (n) cycle();
      sb.delete();
      exp_w = '{0, 0};
      exp_r = '{0, 0};
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 2'b01;
      in_data = '0;
      in_data[0] = 8'h77;
      out_ready = '0;
      repeat (5) cycle();
      n_chk++;
      if (in_ready[0] !== 1'b0 || b_wen[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_hold: in_ready=%0b wen=%0b, want 0 0",
                  in_ready[0], b_wen[0]);
      end
      n_chk++;
      if (out_valid[0] !== 1'b0 || level[0] !== '0 || out_data[0] !== '0) begin
         n_fail++;
         $display("FAIL rst_out: ov=%0b lvl=%0d od=%h, want 0 0 00",
                  out_valid[0], level[0], out_data[0]);
      end
      n_chk++;
      if (b_ren[0] !== 1'b0 || b_waddr[0] !== '0 || b_raddr[0] !== '0
          || b_wdata[0] !== '0) begin
         n_fail++;
         $display("FAIL rst_bank: ren=%0b wa=%0d ra=%0d wd=%h, want 0",
                  b_ren[0], b_waddr[0], b_raddr[0], b_wdata[0]);
      end
      in_valid = '0;
      sb.delete();
      exp_w = '{0, 0};
      exp_r = '{0, 0};
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || level[0] !== '0)
      begin
         n_fail++;
         $display("FAIL rst_release: ir=%0b ov=%0b lvl=%0d, want 1 0 0",
                  in_ready[0], out_valid[0], level[0]);
      end
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (b_wen[0] !== 1'b0 || b_ren[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: wen=%0b ren=%0b, want 0 0",
                     b_wen[0], b_ren[0]);
         end
         cycle();
      end
   endtask

   task automatic test_fill();
      int nacc = 0;
      logic [DW-1:0] d = 8'h01;
      out_ready[0] = 1'b0;
      in_valid[0] = 1'b1;
      in_data[0] = d;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (acc_d[0]) begin
            nacc++;
            d++;
         end
         in_valid[0] = (nacc < 19);
         in_data[0] = d;
      end
      n_chk++;
      if (nacc != 19) begin
         n_fail++;
         $display("FAIL fill_count: got %0d, want 19", nacc);
      end
      n_chk++;
      if (in_ready[0] !== 1'b0 || level[0] !== LW'(19)) begin
         n_fail++;
         $display("FAIL fill_full: ir=%0b lvl=%0d, want 0 19",
                  in_ready[0], level[0]);
      end
      n_chk++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h01) begin
         n_fail++;
         $display("FAIL fill_head: ov=%0b od=%h, want 1 01",
                  out_valid[0], out_data[0]);
      end
      in_valid[0] = 1'b1;
      in_data[0] = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_chk++;
         if (acc_d[0]) begin
            n_fail++;
            $display("FAIL fill_reject: accepted=1, want 0");
         end
      end
      in_valid[0] = 1'b0;
   endtask

   task automatic test_drain();
      int npop = 0;
      logic [2:0] want_ir;
      want_ir = 3'b100;
      out_ready[0] = 1'b1;
      for (int i = 0; i < 60 && npop < 19; i++) begin
         if (i < 3) begin
            n_chk++;
            if (in_ready[0] !== want_ir[i]) begin
               n_fail++;
               $display("FAIL full_reopen[%0d]: got %0b, want %0b",
                        i, in_ready[0], want_ir[i]);
            end
         end
         cycle();
         if (pop_d[0]) npop++;
      end
      out_ready[0] = 1'b0;
      n_chk++;
      if (npop != 19) begin
         n_fail++;
         $display("FAIL drain_count: got %0d, want 19", npop);
      end
      n_chk++;
      if (level[0] !== '0 || out_valid[0] !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_empty: lvl=%0d ov=%0b left=%0d, want 0 0 0",
                  level[0], out_valid[0], sb.size());
      end
   endtask

   task automatic test_streaming();
      int sent = 0;
      int got = 0;
      for (int i = 0; i < 4000 && got < 200; i++) begin
         in_valid[0] = (sent < 200) && ($urandom_range(0, 3) != 0);
         in_data[0] = DW'($urandom);
         out_ready[0] = ($urandom_range(0, 3) != 0);
         cycle();
         if (acc_d[0]) sent++;
         if (pop_d[0]) got++;
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b0;
      n_chk++;
      if (got != 200 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL stream_count: got %0d left %0d, want 200 0",
                  got, sb.size());
      end
      n_chk++;
      if (level[0] !== '0) begin
         n_fail++;
         $display("FAIL stream_level: got %0d, want 0", level[0]);
      end
   endtask

   task automatic test_back_to_back();
      int npop = 0;
      logic [DW-1:0] d = 8'h20;
      in_valid[0] = 1'b1;
      out_ready[0] = 1'b1;
      in_data[0] = d;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (acc_d[0]) d++;
         if (pop_d[0]) npop++;
         in_data[0] = d;
      end
      in_valid[0] = 1'b0;
      n_chk++;
      if (npop < 45) begin
         n_fail++;
         $display("FAIL b2b_rate: got %0d pops/100, want >= 45", npop);
      end
      for (int i = 0; i < 60 && sb.size() != 0; i++) cycle();
      out_ready[0] = 1'b0;
      n_chk++;
      if (sb.size() != 0 || level[0] !== '0) begin
         n_fail++;
         $display("FAIL b2b_drain: left=%0d lvl=%0d, want 0 0",
                  sb.size(), level[0]);
      end
   endtask

   task automatic test_wrap(input int k, input logic [AW-1:0] want_ptr);
      int sent = 0;
      int got = 0;
      apply_reset(3);
      out_ready[k] = 1'b1;
      for (int i = 0; i < 400 && got < 40; i++) begin
         in_valid[k] = (sent < 40);
         in_data[k] = DW'(8'h40 + sent);
         cycle();
         if (acc_d[k]) sent++;
         if (pop_d[k]) got++;
      end
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      n_chk++;
      if (got != 40) begin
         n_fail++;
         $display("FAIL wrap_count[%0d]: got %0d, want 40", k, got);
      end
      n_chk++;
      if (b_waddr[k] !== want_ptr || b_raddr[k] !== want_ptr) begin
         n_fail++;
         $display("FAIL wrap_ptr[%0d]: wa=%0d ra=%0d, want %0d",
                  k, b_waddr[k], b_raddr[k], want_ptr);
      end
   endtask

   task automatic test_reset_midflight();
      int nacc = 0;
      int got = 0;
      int stale = 0;
      apply_reset(3);
      in_valid[0] = 1'b1;
      for (int i = 0; i < 40 && nacc < 10; i++) begin
         in_data[0] = DW'(8'h81 + nacc);
         cycle();
         if (acc_d[0]) nacc++;
      end
      in_valid[0] = 1'b0;
      repeat (3) cycle();
      n_chk++;
      if (level[0] !== LW'(10) || out_valid[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_setup: lvl=%0d ov=%0b, want 10 1",
                  level[0], out_valid[0]);
      end
      out_ready[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_chk++;
         if (!pop_d[0]) begin
            n_fail++;
            $display("FAIL mid_pop[%0d]: popped=0, want 1", i);
         end
      end
      out_ready[0] = 1'b0;
      n_chk++;
      if (level[0] !== LW'(7)) begin
         n_fail++;
         $display("FAIL mid_level: got %0d, want 7", level[0]);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (out_valid[0] !== 1'b0 || level[0] !== '0 || in_ready[0] !== 1'b0
          || b_ren[0] !== 1'b0 || out_data[0] !== '0) begin
         n_fail++;
         $display("FAIL mid_async: ov=%0b lvl=%0d ir=%0b ren=%0b od=%h, want 0",
                  out_valid[0], level[0], in_ready[0], b_ren[0], out_data[0]);
      end
      apply_reset(3);
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (out_valid[0]) stale++;
      end
      n_chk++;
      if (stale != 0) begin
         n_fail++;
         $display("FAIL mid_stale: out_valid cycles %0d, want 0", stale);
      end
      in_valid[0] = 1'b1;
      in_data[0] = 8'h5A;
      out_ready[0] = 1'b1;
      for (int i = 0; i < 20 && got < 1; i++) begin
         cycle();
         if (acc_d[0]) in_valid[0] = 1'b0;
         if (pop_d[0]) got++;
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b0;
      n_chk++;
      if (got != 1 || level[0] !== '0) begin
         n_fail++;
         $display("FAIL mid_resume: pops=%0d lvl=%0d, want 1 0",
                  got, level[0]);
      end
   endtask

   initial begin
      in_valid = '0;
      in_data = '0;
      out_ready = '0;
      acc_d = '0;
      pop_d = '0;
      exp_w = '{0, 0};
      exp_r = '{0, 0};
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_back_to_back();
      test_wrap(0, AW'(8));
      test_wrap(1, AW'(4));
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
